fifo_stream_reader: RTL and testbench

//  Read-side master for the 4-bit FIFO: watches fifo_empty, issues single-cycle fifo_read pulses and

---
 rtl/fifo_reader_pkg.sv | 14 +
 rtl/fifo_stream_reader_if.sv | 34 +++
 rtl/fifo_reader_skid_buf.sv | 60 ++++++
 rtl/fifo_stream_reader.sv | 119 +++++++++++
 tb/tb_fifo_stream_reader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader: FSM state encoding and
// default sizing used by the reader top level, its buffer and its interface.
package fifo_reader_pkg;

    localparam int DATA_W_DEF    = 4;
    localparam int BUF_DEPTH_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream for fifo_stream_reader.
// The master modport is the reader side; the slave modport is the FIFO/consumer side.
interface fifo_stream_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_read,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_read,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_reader_skid_buf.sv
// BUF_DEPTH-entry circular buffer holding words fetched from the FIFO until the
// stream consumer accepts them. The caller guarantees a push never lands on a full buffer.
module fifo_reader_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int BUF_DEPTH = 3,
    localparam int CNT_BITS  = $clog2(BUF_DEPTH + 1),
    localparam int PTR_BITS  = $clog2(BUF_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic [CNT_BITS-1:0] count,
    output logic [DATA_W-1:0]   head_data
);

    logic [DATA_W-1:0]   mem [BUF_DEPTH];
    logic [PTR_BITS-1:0] head_q;
    logic [PTR_BITS-1:0] tail_q;
    logic                do_pop;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(BUF_DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
            // NOTE: storage is reset too so the stream word reads 0 out of reset;
            // with only a few entries this costs nothing worth saving.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_q] <= push_data;
                tail_q      <= ptr_inc(tail_q);
            end
            if (do_pop) begin
                head_q <= ptr_inc(head_q);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a registered-output FIFO, re-presenting words on a valid/ready stream.
// Optional macro FIFO_READER_WCOUNT_EN builds the accepted-beat counter; otherwise word_count is 0.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_count
);

    localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W    = CNT_BITS + 1;

    if (BUF_DEPTH < BUF_DEPTH_MIN) begin : g_depth_check
        $error("fifo_stream_reader: BUF_DEPTH must be at least %0d", BUF_DEPTH_MIN);
    end

    state_t              state_q;
    state_t              state_d;
    logic                fifo_read_q;
    logic                in_flight_q;
    logic                read_d;
    logic                pop;
    logic [CNT_BITS-1:0] count;
    logic [DATA_W-1:0]   head_data;
    logic [SUM_W-1:0]    credit_used;

    assign pop = bus.m_valid && bus.m_ready;

    fifo_reader_skid_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (bus.fifo_data),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    // Every word already held or still on its way reserves a slot; pops in the
    // current cycle are not credited, which keeps ready off the read path.
    assign credit_used = SUM_W'(count) + SUM_W'(in_flight_q) + SUM_W'(fifo_read_q);
    assign read_d      = enable && !bus.fifo_empty && (credit_used < SUM_W'(BUF_DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_read_q <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            fifo_read_q <= read_d;
            in_flight_q <= fifo_read_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if ((count == '0) && !in_flight_q && !fifo_read_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        bus.fifo_read = fifo_read_q;
        bus.m_valid   = (count != '0);
        bus.m_data    = head_data;
    end

`ifdef FIFO_READER_WCOUNT_EN
    logic [CNT_W-1:0] word_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
        end else if (pop) begin
            word_count_q <= word_count_q + CNT_W'(1);
        end
    end

    assign word_count = word_count_q;
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised scoreboard bench for fifo_stream_reader: a FIFO model feeds the reader,
// every word written to the FIFO is expected on the stream in order, exactly once.
module tb_fifo_stream_reader;
    import fifo_reader_pkg::*;

    localparam int DATA_W    = 4;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 4;
    localparam int MEM_SZ    = 4096;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             enable = 1'b0;
    logic             m_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_stream_reader #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Upstream FIFO model: words written by the stimulus, registered data output.
    // Its empty flag discounts a read strobe already in progress.
    logic [DATA_W-1:0] fifo_mem [MEM_SZ];
    logic [DATA_W-1:0] fifo_data_r = '0;
    int n_pushed   = 0;
    int n_consumed = 0;
    int n_reads    = 0;

    assign bus.fifo_data  = fifo_data_r;
    assign bus.fifo_empty = (n_pushed - n_consumed - int'(bus.fifo_read)) <= 0;
    assign bus.m_ready    = m_ready;

    always @(posedge clk) begin
        if (rst) begin
            n_consumed  <= n_pushed;
            fifo_data_r <= '0;
        end else if (bus.fifo_read) begin
            check("read_has_word", 32'(n_consumed < n_pushed), 1);
            n_reads     <= n_reads + 1;
            fifo_data_r <= fifo_mem[n_consumed % MEM_SZ];
            n_consumed  <= n_consumed + 1;
        end
    end

    // Scoreboard and beat-count reference.
    logic [DATA_W-1:0] sb_q [$];
    int                beats = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            beats      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.m_valid) check("hold_data", bus.m_data, prev_data);
            if (bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) begin
                    check("beat_expected", sb_q.size(), 1);
                end else begin
                    check("m_data", bus.m_data, sb_q.pop_front());
                end
                beats++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    function automatic logic [CNT_W-1:0] exp_wc();
`ifdef FIFO_READER_WCOUNT_EN
        return CNT_W'(beats);
`else
        return '0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_mem[n_pushed % MEM_SZ] = w;
        n_pushed++;
        sb_q.push_back(w);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((sb_q.size() != 0 || n_pushed != n_consumed || bus.m_valid ||
                bus.fifo_read || dut.in_flight_q) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tick(2);
        check(name, sb_q.size() + (n_pushed - n_consumed), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] words [4];
        int r0;
        int k;

        // Reset values
        tick(3);
        check("rst_fifo_read", bus.fifo_read, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_word_count", word_count, 0);
        check("rst_state", dut.state_q, ST_IDLE);
        rst    = 1'b0;
        enable = 1'b1;

        // Enabled against an empty FIFO
        tick(10);
        check("t1_no_reads", n_reads, 0);
        check("t1_m_valid", bus.m_valid, 0);
        check("t1_busy", busy, 1);

        // Preloaded FIFO, consumer always ready
        words = '{4'h3, 4'hA, 4'h5, 4'hC};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        wait_drain("t2_drain", 40);
        check("t2_word_count", word_count, exp_wc());

        // Consumer stalled: buffer fills to BUF_DEPTH, head held
        m_ready = 1'b0;
        r0 = n_reads;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        tick(12);
        check("t3_reads", n_reads - r0, 3);
        check("t3_count", dut.u_buf.count, 3);
        check("t3_m_valid", bus.m_valid, 1);
        check("t3_m_data", bus.m_data, 4'h3);
        m_ready = 1'b1;
        wait_drain("t3_drain", 40);
        check("t3_word_count", word_count, exp_wc());

        // Drop enable while a read strobe is out
        for (int i = 0; i < 8; i++) push_word(4'($urandom_range(0, 15)));
        tick(2);
        k = 0;
        while (!bus.fifo_read && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t4_read_seen", bus.fifo_read, 1);
        r0     = n_reads;
        enable = 1'b0;
        tick(1);
        check("t4_state_stop", dut.state_q, ST_STOP);
        k = 0;
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("t4_busy", busy, 0);
        check("t4_state_idle", dut.state_q, ST_IDLE);
        check("t4_reads_after_drop", n_reads - r0, 1);
        enable = 1'b1;
        wait_drain("t4_drain", 60);

        // Reset with two words buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        k = 0;
        while (!(dut.u_buf.count == 2 && dut.in_flight_q) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_point", 32'(dut.u_buf.count == 2 && dut.in_flight_q), 1);
        rst = 1'b1;
        tick(1);
        check("t5_m_valid", bus.m_valid, 0);
        check("t5_word_count", word_count, 0);
        check("t5_busy", busy, 0);
        check("t5_fifo_read", bus.fifo_read, 0);
        check("t5_state", dut.state_q, ST_IDLE);
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(4'($urandom_range(0, 15)));
        wait_drain("t5_drain", 40);

        // Counter wrap: 17 beats from a fresh reset
        pulse_reset();
        for (int i = 0; i < 17; i++) push_word(4'($urandom_range(0, 15)));
        wait_drain("t6_drain", 80);
        check("t6_word_count", word_count, exp_wc());

        // Random traffic, stalls and enable toggles
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) push_word(4'($urandom_range(0, 15)));
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 15) != 0);
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_drain("rand_drain", 300);
        check("rand_word_count", word_count, exp_wc());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
